// File: rtl/row_serializer.sv
// Row-to-word serializer: takes a SIZE-word row in parallel and streams it
// oldest-first (word SIZE-1 down to word 0), with one pending row buffered behind it.
module row_serializer #(
    parameter int SIZE       = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SIZE*DATA_WIDTH-1:0]   data_in,
    input  logic                         load_valid,
    output logic                         load_ready,
    output logic [DATA_WIDTH-1:0]        shift_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    typedef logic [SIZE-1:0][DATA_WIDTH-1:0] row_t;

    row_t             active_row, pending_row;
    row_t             active_row_nxt, pending_row_nxt;
    row_t             row_in;
    logic             active_full, pending_full;
    logic             active_full_nxt, pending_full_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             load_acc, xfer, last_xfer;

    // Packed row layout puts word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
    assign row_in    = data_in;

    assign load_ready = !pending_full;
    assign load_acc   = load_valid && load_ready;
    assign xfer       = active_full && out_ready;
    assign last_xfer  = xfer && (idx == '0);

    // Next-state logic
    always_comb begin
        active_row_nxt   = active_row;
        pending_row_nxt  = pending_row;
        active_full_nxt  = active_full;
        pending_full_nxt = pending_full;
        idx_nxt          = idx;

        if (last_xfer) begin
            if (pending_full) begin
                active_row_nxt   = pending_row;
                pending_full_nxt = 1'b0;
                idx_nxt          = LAST_IDX;
            end else if (load_acc) begin
                active_row_nxt = row_in;
                idx_nxt        = LAST_IDX;
            end else begin
                active_full_nxt = 1'b0;
            end
        end else begin
            if (xfer)
                idx_nxt = idx - IDX_W'(1);
            if (load_acc) begin
                if (!active_full) begin
                    active_row_nxt  = row_in;
                    active_full_nxt = 1'b1;
                    idx_nxt         = LAST_IDX;
                end else begin
                    pending_row_nxt  = row_in;
                    pending_full_nxt = 1'b1;
                end
            end
        end
    end

    // State registers; row data is cleared too so shift_out reads 0 in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_row   <= '0;
            pending_row  <= '0;
            active_full  <= 1'b0;
            pending_full <= 1'b0;
            idx          <= '0;
        end else begin
            active_row   <= active_row_nxt;
            pending_row  <= pending_row_nxt;
            active_full  <= active_full_nxt;
            pending_full <= pending_full_nxt;
            idx          <= idx_nxt;
        end
    end

    // Outputs
    always_comb begin
        out_valid = active_full;
        shift_out = active_full ? active_row[idx] : '0;
        out_last  = active_full && (idx == '0);
        busy      = active_full || pending_full;
    end

endmodule

// File: tb/tb_row_serializer.sv
// Scoreboard bench for row_serializer: loads push expected words, a negedge
// monitor pops and compares on every output transfer.
module tb_row_serializer;

    localparam int SIZE = 5;
    localparam int DW   = 16;
    localparam int RW   = SIZE * DW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [RW-1:0] data_in = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [DW-1:0] shift_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;

    row_serializer #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_out  (shift_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] word;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [RW-1:0] sr = '0;

    logic [RW-1:0] row_basic = 80'h0005_0004_0003_0002_0001;
    logic [RW-1:0] row_a     = 80'h000A_0009_0008_0007_0006;
    logic [RW-1:0] row_b     = 80'h1111_2222_3333_4444_5555;
    logic [RW-1:0] row_c     = 80'hC004_C003_C002_C001_C000;
    logic [RW-1:0] row_d     = 80'hD004_D003_D002_D001_D000;
    logic [RW-1:0] row_e     = 80'hE004_E003_E002_E001_E000;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Holds load_valid until the row is accepted, then scrambles data_in.
    task automatic load_row(input logic [RW-1:0] r);
        int waited = 0;
        data_in    = r;
        load_valid = 1'b1;
        while (!load_ready && waited < 40) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!load_ready) begin
            chk("load_accept_timeout", load_ready, 1);
            load_valid = 1'b0;
            return;
        end
        for (int k = SIZE - 1; k >= 0; k--)
            exp_q.push_back('{word: r[k*DW +: DW], last: (k == 0)});
        @(posedge clock); #1;
        load_valid = 1'b0;
        data_in    = RW'({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    // Monitor: one pop per transfer; also models the downstream shift_register.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", out_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("shift_out", shift_out, mon_e.word);
                chk("out_last", out_last, mon_e.last);
            end
            sr = {sr[RW-DW-1:0], shift_out};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_shift_out", shift_out, 0);
        chk("rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_load_ready", load_ready, 1);

        // Basic row
        out_ready = 1'b1;
        @(posedge clock); #1;
        sr = '0;
        load_row(row_basic);
        repeat (5) @(posedge clock);
        #1;
        chk("basic_cycle6_valid", out_valid, 0);
        chk("basic_shiftreg", sr, row_basic);
        chk("basic_queue", exp_q.size(), 0);

        // Back-to-back rows
        load_row(row_a);
        load_row(row_b);
        chk("b2b_ready_after_second", load_ready, 0);
        for (int k = 2; k <= 10; k++) begin
            @(negedge clock);
            chk("b2b_valid", out_valid, 1);
            chk("b2b_load_ready", load_ready, (k >= 6));
            @(posedge clock);
        end
        #1;
        chk("b2b_end_valid", out_valid, 0);

        // Backpressure on word 0004
        load_row(row_basic);
        @(posedge clock); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("bp_shift_out", shift_out, 16'h0004);
            chk("bp_valid", out_valid, 1);
            chk("bp_last", out_last, 0);
            @(posedge clock);
        end
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("bp_end_valid", out_valid, 0);
        chk("bp_queue", exp_q.size(), 0);

        // Full buffering: third load waits for a row to drain
        out_ready = 1'b0;
        load_row(row_a);
        load_row(row_b);
        data_in    = row_c;
        load_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("full_load_ready", load_ready, 0);
            chk("full_busy", busy, 1);
            @(posedge clock);
        end
        #1;
        out_ready = 1'b1;
        load_row(row_c);
        wait_drain();

        // Reset mid-row after word 0003
        load_row(row_basic);
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_shift_out", shift_out, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clock);
        #1;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_load_ready", load_ready, 1);
        end
        @(posedge clock); #1;
        load_row(row_e);
        chk("fresh_first_word", shift_out, row_e[(SIZE-1)*DW +: DW]);
        wait_drain();

        // New row accepted on the same edge as the last-word transfer
        load_row(row_c);
        repeat (4) @(posedge clock);
        #1;
        load_row(row_d);
        chk("coll_valid", out_valid, 1);
        chk("coll_shift_out", shift_out, row_d[(SIZE-1)*DW +: DW]);
        chk("coll_load_ready", load_ready, 1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
